// File: rtl/sound_tone_player_if.sv
// Bus between the sound generator FSM and the tone player: event pulses and
// enable in, speaker drive and status out.
interface sound_tone_player_if;
  logic       en_i;
  logic       move_i;
  logic       good_i;
  logic       bad_i;
  logic       speaker_o;
  logic       busy_o;
  logic [1:0] snd_id_o;

  modport master (
    output en_i, move_i, good_i, bad_i,
    input  speaker_o, busy_o, snd_id_o
  );

  modport slave (
    input  en_i, move_i, good_i, bad_i,
    output speaker_o, busy_o, snd_id_o
  );
endinterface

// File: rtl/sound_tone_player.sv
// Plays a fixed square-wave note sequence per sound event, with
// bad > good > move priority and preemption by strictly higher priority.
module sound_tone_player #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned HP0      = 5000,
  parameter int unsigned HP1      = 4000,
  parameter int unsigned HP2      = 3000,
  parameter int unsigned HP3      = 2000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic                clk,
  input  logic                rst_i,
  sound_tone_player_if.slave  bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] HP0_LAST = CNT_W'(HP0 - 1);
  localparam logic [CNT_W-1:0] HP1_LAST = CNT_W'(HP1 - 1);
  localparam logic [CNT_W-1:0] HP2_LAST = CNT_W'(HP2 - 1);
  localparam logic [CNT_W-1:0] HP3_LAST = CNT_W'(HP3 - 1);

  state_t           state;
  logic [1:0]       snd_id;
  logic [1:0]       step;
  logic [2:0]       tick;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] hp_cnt;
  logic             speaker;

  logic [1:0]       trig_id;
  logic [1:0]       note;
  logic [2:0]       step_ticks;
  logic [2:0]       tick_last;
  logic             last_step;
  logic [CNT_W-1:0] hp_last;

  always_comb begin
    trig_id = 2'd0;
    if (bus.bad_i)
      trig_id = 2'd3;
    else if (bus.good_i)
      trig_id = 2'd2;
    else if (bus.move_i)
      trig_id = 2'd1;
  end

  // Sequence table: note and length in ticks for each (id, step)
  always_comb begin
    note       = 2'd0;
    step_ticks = 3'd1;
    last_step  = 1'b1;
    case ({snd_id, step})
      4'b01_00: begin note = 2'd3; step_ticks = 3'd1; last_step = 1'b1; end
      4'b10_00: begin note = 2'd1; step_ticks = 3'd2; last_step = 1'b0; end
      4'b10_01: begin note = 2'd2; step_ticks = 3'd2; last_step = 1'b0; end
      4'b10_10: begin note = 2'd3; step_ticks = 3'd2; last_step = 1'b1; end
      4'b11_00: begin note = 2'd2; step_ticks = 3'd4; last_step = 1'b0; end
      4'b11_01: begin note = 2'd0; step_ticks = 3'd6; last_step = 1'b1; end
      default:  begin note = 2'd0; step_ticks = 3'd1; last_step = 1'b1; end
    endcase
  end

  always_comb begin
    tick_last = step_ticks - 3'd1;
    case (note)
      2'd0:    hp_last = HP0_LAST;
      2'd1:    hp_last = HP1_LAST;
      2'd2:    hp_last = HP2_LAST;
      default: hp_last = HP3_LAST;
    endcase
  end

  // snd_id is 0 while idle, so "trig_id > snd_id" covers both start and preemption
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state   <= IDLE;
      snd_id  <= 2'd0;
      step    <= 2'd0;
      tick    <= 3'd0;
      cyc_cnt <= '0;
      hp_cnt  <= '0;
      speaker <= 1'b0;
    end else if (bus.en_i && (trig_id > snd_id)) begin
      state   <= PLAY;
      snd_id  <= trig_id;
      step    <= 2'd0;
      tick    <= 3'd0;
      cyc_cnt <= '0;
      hp_cnt  <= '0;
      speaker <= 1'b0;
    end else if (state == PLAY) begin
      if (!bus.en_i) begin
        state   <= IDLE;
        snd_id  <= 2'd0;
        step    <= 2'd0;
        tick    <= 3'd0;
        cyc_cnt <= '0;
        hp_cnt  <= '0;
        speaker <= 1'b0;
      end else begin
        if (hp_cnt == hp_last) begin
          hp_cnt  <= '0;
          speaker <= ~speaker;
        end else begin
          hp_cnt <= hp_cnt + 1'b1;
        end

        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt <= '0;
          if (tick == tick_last) begin
            // Step boundary: the next note always starts from a low speaker
            tick    <= 3'd0;
            hp_cnt  <= '0;
            speaker <= 1'b0;
            if (last_step) begin
              state  <= IDLE;
              snd_id <= 2'd0;
              step   <= 2'd0;
            end else begin
              step <= step + 2'd1;
            end
          end else begin
            tick <= tick + 3'd1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.speaker_o = speaker;
  assign bus.busy_o    = (state == PLAY);
  assign bus.snd_id_o  = snd_id;

endmodule

// File: tb/tb_sound_tone_player.sv
// Self-checking bench: scenario tasks plus a randomized run, all compared
// against a cycle-level model built from the note tables.
module tb_sound_tone_player;

  localparam int TD = 4;

  logic tb_clk;
  logic tb_rst;
  int   vectors;
  int   miscompares;

  sound_tone_player_if bus();

  sound_tone_player #(
    .TICK_DIV (TD),
    .HP0      (5),
    .HP1      (6),
    .HP2      (4),
    .HP3      (2),
    .CNT_W    (8)
  ) dut (
    .clk   (tb_clk),
    .rst_i (tb_rst),
    .bus   (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Reference model: current sequence id, step index and cycles elapsed in step
  int m_id   = 0;
  int m_step = 0;
  int m_t    = 0;

  function automatic int seq_len(input int id);
    case (id)
      1: return 1;
      2: return 3;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int step_ticks(input int id, input int s);
    case (id)
      1: return 1;
      2: return 2;
      3: return (s == 0) ? 4 : 6;
      default: return 1;
    endcase
  endfunction

  function automatic int step_hp(input int id, input int s);
    int n;
    case (id)
      1: n = 3;
      2: n = s + 1;
      3: n = (s == 0) ? 2 : 0;
      default: n = 0;
    endcase
    case (n)
      0: return 5;
      1: return 6;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  always @(posedge tb_clk) begin : model
    int trig;
    trig = bus.bad_i ? 3 : bus.good_i ? 2 : bus.move_i ? 1 : 0;
    if (tb_rst || !bus.en_i) begin
      m_id = 0; m_step = 0; m_t = 0;
    end else if (trig > m_id) begin
      m_id = trig; m_step = 0; m_t = 0;
    end else if (m_id != 0) begin
      m_t = m_t + 1;
      if (m_t == step_ticks(m_id, m_step) * TD) begin
        m_t    = 0;
        m_step = m_step + 1;
        if (m_step == seq_len(m_id)) begin
          m_id = 0; m_step = 0;
        end
      end
    end
  end

  function automatic logic [3:0] expected();
    logic spk;
    if (m_id == 0) return 4'b0000;
    spk = ((m_t / step_hp(m_id, m_step)) % 2) != 0;
    return {spk, 1'b1, 2'(m_id)};
  endfunction

  function automatic logic [3:0] observed();
    return {bus.speaker_o, bus.busy_o, bus.snd_id_o};
  endfunction

  task automatic clear_inputs();
    bus.move_i = 1'b0;
    bus.good_i = 1'b0;
    bus.bad_i  = 1'b0;
  endtask

  task automatic test_reset();
    tb_rst = 1'b1;
    repeat (2) @(negedge tb_clk);
    vectors++;
    if (observed() !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_initial got %b want %b", observed(), 4'b0000);
    end
    tb_rst = 1'b0;
    bus.bad_i = 1'b1;
    @(negedge tb_clk);
    bus.bad_i = 1'b0;
    repeat (10) @(negedge tb_clk);
    tb_rst = 1'b1;
    repeat (2) @(negedge tb_clk);
    tb_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (observed() !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_bad c=%0d got %b want %b", c, observed(), 4'b0000);
      end
      @(negedge tb_clk);
    end
  endtask

  task automatic test_move();
    logic [3:0] want [4] = '{4'b0101, 4'b0101, 4'b1101, 4'b1101};
    bus.move_i = 1'b1;
    @(negedge tb_clk);
    bus.move_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (observed() !== want[c] || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL move_wave c=%0d got %b want %b model %b", c, observed(), want[c], expected());
      end
      @(negedge tb_clk);
    end
    vectors++;
    if (observed() !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL move_end got %b want %b", observed(), 4'b0000);
    end
  endtask

  task automatic test_good();
    int busy_cnt = 0;
    bus.good_i = 1'b1;
    @(negedge tb_clk);
    bus.good_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL good_model c=%0d got %b want %b", c, observed(), expected());
      end
      if (bus.busy_o) busy_cnt++;
      if (c == 0 || c == 8 || c == 16) begin
        vectors++;
        if ({bus.speaker_o, bus.snd_id_o} !== 3'b010) begin
          miscompares++;
          $display("[TB] FAIL good_step_start c=%0d got %b want %b", c, {bus.speaker_o, bus.snd_id_o}, 3'b010);
        end
      end
      if (c == 5 || c == 6) begin
        vectors++;
        if (bus.speaker_o !== (c == 6)) begin
          miscompares++;
          $display("[TB] FAIL good_first_toggle c=%0d got %b want %b", c, bus.speaker_o, (c == 6));
        end
      end
      @(negedge tb_clk);
    end
    vectors++;
    if (busy_cnt !== 24) begin
      miscompares++;
      $display("[TB] FAIL good_busy_len got %0d want %0d", busy_cnt, 24);
    end
  endtask

  task automatic test_priority();
    int busy_cnt = 0;
    int bad_cnt  = 0;
    bus.good_i = 1'b1;
    bus.move_i = 1'b1;
    @(negedge tb_clk);
    clear_inputs();
    vectors++;
    if (bus.snd_id_o !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL prio_good_over_move got %0d want %0d", bus.snd_id_o, 2);
    end
    for (int c = 0; c < 40; c++) begin
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL prio_move_ignored c=%0d got %b want %b", c, observed(), expected());
      end
      if (bus.busy_o) busy_cnt++;
      bus.move_i = (c == 5);
      @(negedge tb_clk);
    end
    vectors++;
    if (busy_cnt !== 24) begin
      miscompares++;
      $display("[TB] FAIL prio_move_busy_len got %0d want %0d", busy_cnt, 24);
    end
    bus.good_i = 1'b1;
    @(negedge tb_clk);
    bus.good_i = 1'b0;
    repeat (10) @(negedge tb_clk);
    bus.bad_i = 1'b1;
    @(negedge tb_clk);
    bus.bad_i = 1'b0;
    vectors++;
    if (observed() !== 4'b0111) begin
      miscompares++;
      $display("[TB] FAIL prio_bad_preempt got %b want %b", observed(), 4'b0111);
    end
    for (int c = 0; c < 50; c++) begin
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL prio_bad_model c=%0d got %b want %b", c, observed(), expected());
      end
      if (bus.busy_o && bus.snd_id_o == 2'd3) bad_cnt++;
      @(negedge tb_clk);
    end
    vectors++;
    if (bad_cnt !== 40) begin
      miscompares++;
      $display("[TB] FAIL prio_bad_busy_len got %0d want %0d", bad_cnt, 40);
    end
  endtask

  task automatic test_enable();
    bus.en_i  = 1'b0;
    bus.bad_i = 1'b1;
    @(negedge tb_clk);
    bus.bad_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (bus.busy_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL enable_off_ignored c=%0d got %b want %b", c, bus.busy_o, 1'b0);
      end
      @(negedge tb_clk);
    end
    bus.en_i   = 1'b1;
    bus.good_i = 1'b1;
    @(negedge tb_clk);
    bus.good_i = 1'b0;
    repeat (6) @(negedge tb_clk);
    bus.en_i = 1'b0;
    @(negedge tb_clk);
    vectors++;
    if (observed() !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL enable_drop got %b want %b", observed(), 4'b0000);
    end
    bus.en_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      vectors++;
      if (observed() !== 4'b0000 || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL enable_no_resume c=%0d got %b want %b", c, observed(), 4'b0000);
      end
      @(negedge tb_clk);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0;
    bus.good_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge tb_clk);
      if (c == 2) bus.good_i = 1'b0;
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL retrigger_model c=%0d got %b want %b", c, observed(), expected());
      end
      if (bus.busy_o) busy_cnt++;
    end
    vectors++;
    if (busy_cnt !== 24) begin
      miscompares++;
      $display("[TB] FAIL retrigger_busy_len got %0d want %0d", busy_cnt, 24);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL random_model c=%0d got %b want %b", c, observed(), expected());
      end
      tb_rst     = ($urandom_range(0, 299) == 0);
      bus.en_i   = ($urandom_range(0, 39) != 0);
      bus.move_i = ($urandom_range(0, 11) == 0);
      bus.good_i = ($urandom_range(0, 29) == 0);
      bus.bad_i  = ($urandom_range(0, 59) == 0);
      @(negedge tb_clk);
    end
    tb_rst = 1'b0;
    bus.en_i = 1'b1;
    clear_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tb_rst      = 1'b1;
    bus.en_i    = 1'b1;
    clear_inputs();
    @(negedge tb_clk);
    test_reset();
    test_move();
    test_good();
    test_priority();
    test_enable();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_tone_player.md
Name: sound_tone_player

Overview:
- Downstream of the sound generator FSM: consumes its one-cycle sound event pulses (move, good collision, bad collision) and the sound-enable mode.
- Plays a short fixed note sequence per event as a square wave on the speaker pin.
- Handles sequencing, per-note duration timing, tone frequency division and event priority/preemption.

Parameters:
- TICK_DIV, 100000: clock cycles per duration tick (the note-length unit); must be >= 1.
- HP0, 5000: half-period of note N0 in clock cycles; must be >= 1.
- HP1, 4000: half-period of note N1 in clock cycles; must be >= 1.
- HP2, 3000: half-period of note N2 in clock cycles; must be >= 1.
- HP3, 2000: half-period of note N3 in clock cycles; must be >= 1.
- CNT_W, 20: width of the tick and half-period counters; must hold max(TICK_DIV, HP0..HP3).

Ports:
- clk  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- en_i  input  1  sound enable (mode ON = 1)
- move_i  input  1  one-cycle pulse: snake moved/turned
- good_i  input  1  one-cycle pulse: good collision (food)
- bad_i  input  1  one-cycle pulse: bad collision (death)
- speaker_o  output  1  square-wave speaker drive
- busy_o  output  1  high while a sequence is playing
- snd_id_o  output  2  sequence playing: 0 none, 1 move, 2 good, 3 bad

Behaviour:
- Reset (rst_i high at posedge):
  - state IDLE; speaker_o=0, busy_o=0, snd_id_o=0.
  - All counters cleared.
  - Reset wins over every other input, including mid-sequence.
- Sequences, as (note, ticks) steps:
  - move (id 1): (N3,1).
  - good (id 2): (N1,2), (N2,2), (N3,2).
  - bad (id 3): (N2,4), (N0,6).
- States:
  - IDLE: speaker_o=0, busy_o=0.
  - PLAY: holds current sequence id, step index, tick counter, cycle-in-tick counter and half-period counter.
- Start:
  - Trigger sampled high at posedge k with en_i=1 and no reset: at k+1 the state is PLAY, step 0 begins, all counters are 0, speaker_o=0, busy_o=1, and snd_id_o is set.
  - Triggers with en_i=0 are ignored.
- Priority (simultaneous triggers): bad > good > move.
- While busy:
  - A trigger of strictly higher priority than the current id preempts: restart at step 0 of the new sequence on the next cycle, same timing as from IDLE.
  - A trigger of equal or lower priority is ignored; no retrigger, no queueing.
- Tone:
  - Half-period counter increments every PLAY cycle.
  - When it equals HPn-1, it clears and speaker_o toggles.
  - At every step start the counter clears and speaker_o is forced to 0.
- Duration:
  - Cycle counter wraps at TICK_DIV-1.
  - A step ends after exactly ticks*TICK_DIV cycles.
  - The next step starts the following cycle.
  - After the last step the block returns to IDLE: busy_o=0, speaker_o=0, snd_id_o=0.
  - Total busy cycles: move 1*TICK_DIV, good 6*TICK_DIV, bad 10*TICK_DIV.
- en_i falling while PLAY: next cycle IDLE with all outputs 0; the sequence is abandoned, not resumed.
- Triggers are edge-free: one pulse = one request. Inputs held high are treated as a new request each cycle, subject to the priority rules above; they never restart a sequence of equal id.

Test Plan:
- Reset: rst_i high 2 cycles mid-bad-sequence -> next cycle speaker_o=0, busy_o=0, snd_id_o=0; stays idle.
- Move, with TICK_DIV=4, HP3=2: move_i pulse at posedge k -> speaker_o=0,0,1,1 in cycles k+1..k+4; busy_o=1 and snd_id_o=1 for exactly those 4 cycles; IDLE at k+5.
- Good, with TICK_DIV=4, HP1=6, HP2=4, HP3=2: good_i pulse -> busy_o high exactly 24 cycles.
  - First toggle at the 6th cycle of step 0.
  - Steps start at offsets 0, 8, 16 with speaker_o=0 at each.
  - snd_id_o=2 throughout.
- Priority/preemption:
  - good_i and move_i in the same cycle -> snd_id_o=2.
  - During good, move_i pulse -> ignored; total busy stays 24.
  - During good, bad_i pulse -> next cycle snd_id_o=3, step 0 of bad; busy lasts 40 more cycles.
- Enable: en_i=0, bad_i pulse -> busy_o stays 0. en_i dropped mid-good -> next cycle busy_o=0, speaker_o=0; re-enabling does not resume.
- Equal retrigger: good_i held high for 3 cycles -> one 24-cycle sequence, no restart.
